// File: rtl/simple_system.sv
// Serial weighted bit-sum: Z = sum of (i+1) for each set bit X[i], computed over
// four BUSY cycles behind a start/ready handshake.
module simple_system (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] X,
    output logic       ready,
    output logic [3:0] Z
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] z_q, z_d;
    logic [3:0] addend;
    logic [3:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            cnt_q   <= 2'd0;
            acc_q   <= 4'd0;
            z_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
        end
    end

    // Weight of the bit under the cursor is its index plus one.
    assign addend = a_q[cnt_q] ? ({2'b00, cnt_q} + 4'd1) : 4'd0;
    assign sum    = acc_q + addend;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = X;
                    acc_d   = 4'd0;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = sum;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    z_d     = sum;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign Z     = z_q;

endmodule

// File: tb/tb_simple_system.sv
// Directed bench for simple_system: handshake timing, weighted sums, back-to-back
// operation and asynchronous reset behaviour.
module tb_simple_system;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] X;
    logic       ready;
    logic [3:0] Z;

    int n_cmp = 0;
    int n_err = 0;

    simple_system dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .ready (ready),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted request: ready low after the accepting edge and the next three,
    // Z unchanged meanwhile, then ready high with the new result.
    task automatic test_op(input logic [3:0] x, input logic [3:0] exp_z,
                           input logic [3:0] prev_z, input bit scramble, input string name);
        X = x;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            n_cmp++;
            if (ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy%0d ready: got %b want 0", name, i, ready);
            end
            n_cmp++;
            if (Z !== prev_z) begin
                n_err++;
                $display("FAIL %s busy%0d Z: got %0d want %0d", name, i, Z, prev_z);
            end
            if (scramble) begin
                X = 4'b1111;
                start = (i < 3) ? ~start : 1'b0;
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s done ready: got %b want 1", name, ready);
        end
        n_cmp++;
        if (Z !== exp_z) begin
            n_err++;
            $display("FAIL %s done Z: got %0d want %0d", name, Z, exp_z);
        end
        $display("op %s: X=%b Z=%0d (want %0d)", name, x, Z, exp_z);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        X = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset ready: got %b want 1", ready);
        end
        n_cmp++;
        if (Z !== 4'd0) begin
            n_err++;
            $display("FAIL reset Z: got %0d want 0", Z);
        end
        rst = 1'b0;
        $display("reset: ready=%b Z=%0d", ready, Z);
    endtask

    task automatic test_basic();
        test_op(4'b0101, 4'd4, 4'd0, 1'b0, "x0101");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ready !== 1'b1 || Z !== 4'd4) begin
                n_err++;
                $display("FAIL idle_hold%0d: got ready=%b Z=%0d want ready=1 Z=4", i, ready, Z);
            end
        end
    endtask

    task automatic test_x_change();
        test_op(4'b0110, 4'd5, 4'd4, 1'b1, "x0110_scramble");
    endtask

    task automatic test_extremes();
        test_op(4'b1111, 4'd10, 4'd5, 1'b0, "x1111");
        test_op(4'b0000, 4'd0, 4'd10, 1'b0, "x0000");
    endtask

    task automatic test_back_to_back();
        logic       exp_ready;
        logic [3:0] exp_z;
        X = 4'b1000;
        start = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            exp_ready = (j == 4) || (j == 9);
            exp_z = (j < 4) ? 4'd0 : 4'd4;
            n_cmp++;
            if (ready !== exp_ready) begin
                n_err++;
                $display("FAIL b2b edge%0d ready: got %b want %b", j, ready, exp_ready);
            end
            n_cmp++;
            if (Z !== exp_z) begin
                n_err++;
                $display("FAIL b2b edge%0d Z: got %0d want %0d", j, Z, exp_z);
            end
            $display("b2b edge %0d: ready=%b Z=%0d", j, ready, Z);
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        X = 4'b1111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst ready: got %b want 1", ready);
        end
        n_cmp++;
        if (Z !== 4'd0) begin
            n_err++;
            $display("FAIL async_rst Z: got %0d want 0", Z);
        end
        $display("async reset mid-op: ready=%b Z=%0d", ready, Z);
        @(posedge clk); #1;
        rst = 1'b0;
        test_op(4'b0011, 4'd3, 4'd0, 1'b0, "x0011_after_rst");
    endtask

    task automatic test_reset_hold();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            X = 4'(4'hF - i);
            @(posedge clk); #1;
            n_cmp++;
            if (ready !== 1'b1 || Z !== 4'd0) begin
                n_err++;
                $display("FAIL rst_hold%0d: got ready=%b Z=%0d want ready=1 Z=0", i, ready, Z);
            end
        end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b1 || Z !== 4'd0) begin
            n_err++;
            $display("FAIL rst_release: got ready=%b Z=%0d want ready=1 Z=0", ready, Z);
        end
        $display("reset hold: ready=%b Z=%0d", ready, Z);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        X = 4'd0;
        test_reset();
        test_basic();
        test_x_change();
        test_extremes();
        test_back_to_back();
        test_async_reset();
        test_reset_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
